// File: rtl/axis_width_upsizer.sv
// AXI-Stream width upsizer: packs RATIO narrow beats (first beat in the
// lowest bytes) into one wide output word held in a single output register.
// A word closes when the last slot is filled or when s_axis_tlast arrives;
// unfilled bytes and keep bits of an early-closed word stay zero.
module axis_width_upsizer #(
  parameter int slave_width  = 2,
  parameter int master_width = 16
) (
  input  logic                      aclk,
  input  logic                      arst,
  input  logic [slave_width*8-1:0]  s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [master_width*8-1:0] m_axis_tdata,
  output logic [master_width-1:0]   m_axis_tkeep,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready
);

  localparam int RATIO = master_width / slave_width;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int SWB   = slave_width * 8;
  localparam int MWB   = master_width * 8;

  generate
    if (slave_width < 1 || (master_width % slave_width) != 0 || RATIO < 1) begin : g_bad_width
      $error("axis_width_upsizer: master_width must be a positive multiple of slave_width");
    end
  endgenerate

  logic [MWB-1:0]          r_asm_data;
  logic [master_width-1:0] r_asm_keep;
  logic [CNT_W-1:0]        r_cnt;
  logic [MWB-1:0]          r_m_data;
  logic [master_width-1:0] r_m_keep;
  logic                    r_m_last;
  logic                    r_m_valid;

  logic                    w_s_ready;
  logic                    w_accept;
  logic                    w_last_slot;
  logic                    w_complete;
  logic [MWB-1:0]          w_merge_data;
  logic [master_width-1:0] w_merge_keep;

  assign w_s_ready   = ~r_m_valid | m_axis_tready;
  assign w_accept    = s_axis_tvalid & w_s_ready;
  assign w_last_slot = (r_cnt == CNT_W'(RATIO - 1));
  assign w_complete  = w_accept & (w_last_slot | s_axis_tlast);

  // Assembly contents with the incoming beat dropped into slot r_cnt.
  always_comb begin
    w_merge_data = r_asm_data;
    w_merge_keep = r_asm_keep;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_merge_data[i*SWB +: SWB]                 = s_axis_tdata;
        w_merge_keep[i*slave_width +: slave_width] = '1;
      end
    end
  end

  // Assembly register: accumulate beats, clear once the word is handed off.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_asm_data <= '0;
      r_asm_keep <= '0;
      r_cnt      <= '0;
    end else if (w_accept) begin
      if (w_complete) begin
        r_asm_data <= '0;
        r_asm_keep <= '0;
        r_cnt      <= '0;
      end else begin
        r_asm_data <= w_merge_data;
        r_asm_keep <= w_merge_keep;
        r_cnt      <= r_cnt + 1'b1;
      end
    end
  end

  // Output register: reload on a completed word (even while draining), else
  // drop valid once the downstream takes the word; payload holds otherwise.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_m_data  <= '0;
      r_m_keep  <= '0;
      r_m_last  <= 1'b0;
      r_m_valid <= 1'b0;
    end else if (w_complete) begin
      r_m_data  <= w_merge_data;
      r_m_keep  <= w_merge_keep;
      r_m_last  <= s_axis_tlast;
      r_m_valid <= 1'b1;
    end else if (m_axis_tready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign s_axis_tready = w_s_ready;
  assign m_axis_tdata  = r_m_data;
  assign m_axis_tkeep  = r_m_keep;
  assign m_axis_tlast  = r_m_last;
  assign m_axis_tvalid = r_m_valid;

endmodule
